// File: rtl/verdict_pkg.sv
`default_nettype none
// ============================================================================
// Module  : verdict_pkg
// Brief   : Shared record layout, FSM states and sizing helpers for the
//           verdict stream collector.
// Rev     : 1.0  initial release
// ============================================================================
package verdict_pkg;

    localparam int DEF_N_OUTPUTS = 6;
    localparam int DEF_DATA_W    = 64;
    localparam int DEF_TS_W      = 32;
    localparam int DEF_DEPTH     = 8;
    localparam int DEF_DROP_W    = 16;

    function automatic int idx_w(input int n_outputs);
        return (n_outputs > 1) ? $clog2(n_outputs) : 1;
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // One captured monitor cycle: when it happened, which outputs fired, what they said.
    typedef struct packed {
        logic [DEF_TS_W-1:0]                 ts;
        logic [DEF_N_OUTPUTS-1:0]            mask;
        logic [DEF_N_OUTPUTS*DEF_DATA_W-1:0] values;
    } record_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/verdict_record_fifo.sv
`default_nettype none
// ============================================================================
// Module  : verdict_record_fifo
// Brief   : Synchronous circular-buffer FIFO with a show-ahead head and an
//           occupancy count; a push while full is accepted if a pop shares the edge.
// Rev     : 1.0  initial release
// ============================================================================
module verdict_record_fifo
    import verdict_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic [WIDTH-1:0]          i_push_data,
    input  logic                      i_pop,
    output logic [WIDTH-1:0]          o_head,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [lvl_w(DEPTH)-1:0]   o_level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = lvl_w(DEPTH);
    localparam logic [LVL_W-1:0] c_full_level = LVL_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_full_level);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_level   = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/verdict_stream_collector.sv
`default_nettype none
// ============================================================================
// Module  : verdict_stream_collector
// Brief   : Timestamps active monitor cycles, queues them as records and
//           serialises each record into one stream beat per active output.
//           Optional macro VERDICT_STREAM_COLLECTOR_DROP_CNT_EN adds a
//           saturating dropped-record counter on drop_cnt.
// Rev     : 1.0  initial release
// ============================================================================
module verdict_stream_collector
    import verdict_pkg::*;
#(
    parameter int N_OUTPUTS = DEF_N_OUTPUTS,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int TS_W      = DEF_TS_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int DROP_W    = DEF_DROP_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic [N_OUTPUTS*DATA_W-1:0]     out_values,
    input  logic [N_OUTPUTS-1:0]            out_aktv,
    output logic                            s_valid,
    input  logic                            s_ready,
    output logic [TS_W-1:0]                 s_ts,
    output logic [idx_w(N_OUTPUTS)-1:0]     s_idx,
    output logic [DATA_W-1:0]               s_value,
    output logic                            s_last,
    output logic [lvl_w(DEPTH)-1:0]         fifo_level,
    output logic                            overflow,
    output logic [DROP_W-1:0]               drop_cnt
);

    localparam int IDX_W = idx_w(N_OUTPUTS);

    state_t                         r_state;
    logic [TS_W-1:0]                r_ts_cnt;
    logic [N_OUTPUTS-1:0]           r_mask;
    logic [N_OUTPUTS*DATA_W-1:0]    r_values;

    record_t                        w_push_rec;
    record_t                        w_head;
    logic                           w_push;
    logic                           w_pop;
    logic                           w_full;
    logic                           w_empty;
    logic                           w_drop;
    logic                           w_advance;
    logic [N_OUTPUTS-1:0]           w_load_mask;
    logic [N_OUTPUTS*DATA_W-1:0]    w_load_values;
    logic [IDX_W-1:0]               w_sel_idx;
    logic [DATA_W-1:0]              w_sel_value;
    logic                           w_sel_last;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_OUTPUTS-1:0] m);
        lowest_set = '0;
        for (int i = N_OUTPUTS - 1; i >= 0; i--) begin
            if (m[i]) begin
                lowest_set = IDX_W'(i);
            end
        end
    endfunction

    assign w_push     = en && (|out_aktv);
    assign w_push_rec = '{ts: r_ts_cnt, mask: out_aktv, values: out_values};
    assign w_advance  = (r_state == EMIT) && s_ready;
    // Refill straight from the FIFO on the last handshake so records leave back to back.
    assign w_pop      = !w_empty && ((r_state == IDLE) || (w_advance && s_last));
    assign w_drop     = w_push && w_full && !w_pop;

    verdict_record_fifo #(
        .WIDTH (($bits(record_t))),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_rec),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (fifo_level)
    );

    // Next beat is picked from either a freshly popped record or the remaining mask.
    assign w_load_mask   = w_pop ? w_head.mask   : (r_mask & (r_mask - 1'b1));
    assign w_load_values = w_pop ? w_head.values : r_values;

    always_comb begin
        w_sel_idx   = lowest_set(w_load_mask);
        w_sel_value = '0;
        for (int i = 0; i < N_OUTPUTS; i++) begin
            if (IDX_W'(i) == w_sel_idx) begin
                w_sel_value = w_load_values[i*DATA_W +: DATA_W];
            end
        end
        w_sel_last = (w_load_mask != '0) &&
                     ((w_load_mask & (w_load_mask - 1'b1)) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (en) begin
                r_ts_cnt <= r_ts_cnt + 1'b1;
            end
            if (w_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mask   <= '0;
            r_values <= '0;
            s_valid  <= 1'b0;
            s_ts     <= '0;
            s_idx    <= '0;
            s_value  <= '0;
            s_last   <= 1'b0;
        end else if (w_pop) begin
            r_state  <= EMIT;
            r_mask   <= w_load_mask;
            r_values <= w_load_values;
            s_valid  <= 1'b1;
            s_ts     <= w_head.ts;
            s_idx    <= w_sel_idx;
            s_value  <= w_sel_value;
            s_last   <= w_sel_last;
        end else if (w_advance) begin
            if (s_last) begin
                r_state <= IDLE;
                r_mask  <= '0;
                s_valid <= 1'b0;
            end else begin
                r_mask  <= w_load_mask;
                s_idx   <= w_sel_idx;
                s_value <= w_sel_value;
                s_last  <= w_sel_last;
            end
        end
    end

`ifdef VERDICT_STREAM_COLLECTOR_DROP_CNT_EN
    logic [DROP_W-1:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_verdict_stream_collector.sv
`default_nettype none
// ============================================================================
// Module  : tb_verdict_stream_collector
// Brief   : Directed self-checking bench for verdict_stream_collector.
// Rev     : 1.0  initial release
// ============================================================================
module tb_verdict_stream_collector;

    localparam int N  = 6;
    localparam int DW = 64;

`ifdef VERDICT_STREAM_COLLECTOR_DROP_CNT_EN
    localparam logic [15:0] EXP_DROP = 16'd1;
`else
    localparam logic [15:0] EXP_DROP = 16'd0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            en;
    logic [N*DW-1:0] out_values;
    logic [N-1:0]    out_aktv;
    logic            s_valid;
    logic            s_ready;
    logic [31:0]     s_ts;
    logic [2:0]      s_idx;
    logic [63:0]     s_value;
    logic            s_last;
    logic [3:0]      fifo_level;
    logic            overflow;
    logic [15:0]     drop_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    verdict_stream_collector dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .out_values (out_values),
        .out_aktv   (out_aktv),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_ts       (s_ts),
        .s_idx      (s_idx),
        .s_value    (s_value),
        .s_last     (s_last),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [31:0] ts, input logic [2:0] idx,
                        input logic [63:0] val, input logic last);
        chk({tag, ".valid"}, 64'(s_valid), 64'd1);
        chk({tag, ".ts"},    64'(s_ts),    64'(ts));
        chk({tag, ".idx"},   64'(s_idx),   64'(idx));
        chk({tag, ".value"}, s_value,      val);
        chk({tag, ".last"},  64'(s_last),  64'(last));
    endtask

    task automatic set_val(input int i, input logic [63:0] v);
        out_values[i*DW +: DW] = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        s_ready    = 1'b0;
        out_aktv   = '0;
        out_values = '0;
        step();
        step();

        // Reset state
        chk("rst.valid",    64'(s_valid),    64'd0);
        chk("rst.ts",       64'(s_ts),       64'd0);
        chk("rst.last",     64'(s_last),     64'd0);
        chk("rst.level",    64'(fifo_level), 64'd0);
        chk("rst.overflow", 64'(overflow),   64'd0);
        chk("rst.drop",     64'(drop_cnt),   64'd0);
        rst = 1'b0;

        // Single record at ts=5
        en      = 1'b1;
        s_ready = 1'b1;
        repeat (5) step();
        out_aktv = 6'b000101;
        for (int i = 0; i < N; i++) set_val(i, 64'd99);
        set_val(0, 64'd1);
        set_val(2, 64'd3);
        step();
        out_aktv = '0;
        chk("single.valid0", 64'(s_valid),    64'd0);
        chk("single.level",  64'(fifo_level), 64'd1);
        step();
        beat("single.b0", 32'd5, 3'd0, 64'd1, 1'b0);
        chk("single.level_emit", 64'(fifo_level), 64'd0);
        step();
        beat("single.b1", 32'd5, 3'd2, 64'd3, 1'b1);
        step();
        chk("single.idle", 64'(s_valid), 64'd0);

        // Back-to-back records at ts 9,10,11
        out_aktv = 6'b000010; set_val(1, 64'd11);
        step();
        out_aktv = 6'b100001; set_val(0, 64'd20); set_val(5, 64'd25);
        step();
        beat("b2b.A", 32'd9, 3'd1, 64'd11, 1'b1);
        out_aktv = 6'b001000; set_val(3, 64'd33);
        step();
        beat("b2b.B0", 32'd10, 3'd0, 64'd20, 1'b0);
        out_aktv = '0;
        step();
        beat("b2b.B1", 32'd10, 3'd5, 64'd25, 1'b1);
        step();
        beat("b2b.C", 32'd11, 3'd3, 64'd33, 1'b1);
        step();
        chk("b2b.idle", 64'(s_valid), 64'd0);

        // Backpressure: 10 records against a stalled sink, ts 15..24
        s_ready  = 1'b0;
        out_aktv = 6'b000011;
        for (int k = 0; k < 9; k++) begin
            set_val(0, 64'(100 + k));
            set_val(1, 64'(200 + k));
            step();
        end
        chk("bp.level_full", 64'(fifo_level), 64'd8);
        chk("bp.no_ovf_yet", 64'(overflow),   64'd0);
        set_val(0, 64'd109);
        set_val(1, 64'd209);
        step();
        chk("bp.level",    64'(fifo_level), 64'd8);
        chk("bp.overflow", 64'(overflow),   64'd1);
        chk("bp.drop",     64'(drop_cnt),   64'(EXP_DROP));
        beat("bp.head", 32'd15, 3'd0, 64'd100, 1'b0);
        out_aktv = '0;
        step();
        beat("bp.hold", 32'd15, 3'd0, 64'd100, 1'b0);

        // Full FIFO with a capture on the same edge as the last-beat pop
        s_ready = 1'b1;
        step();
        beat("full.r0b1", 32'd15, 3'd1, 64'd200, 1'b1);
        chk("full.level_pre", 64'(fifo_level), 64'd8);
        out_aktv = 6'b001000; set_val(3, 64'd77);
        step();
        beat("full.r1b0", 32'd16, 3'd0, 64'd101, 1'b0);
        chk("full.level", 64'(fifo_level), 64'd8);
        chk("full.drop",  64'(drop_cnt),   64'(EXP_DROP));

        // en gating: nothing captured, ts frozen at 28, drain keeps going
        en       = 1'b0;
        out_aktv = 6'b111111;
        step();
        beat("en.r1b1", 32'd16, 3'd1, 64'd201, 1'b1);
        step();
        beat("en.r2b0", 32'd17, 3'd0, 64'd102, 1'b0);
        chk("en.level7", 64'(fifo_level), 64'd7);
        step();
        step();
        beat("en.r3b0", 32'd18, 3'd0, 64'd103, 1'b0);
        chk("en.level6", 64'(fifo_level), 64'd6);
        en       = 1'b1;
        out_aktv = 6'b000001; set_val(0, 64'd55);
        step();
        beat("en.r3b1", 32'd18, 3'd1, 64'd203, 1'b1);
        chk("en.level7b", 64'(fifo_level), 64'd7);
        out_aktv = '0;
        repeat (9) step();
        step();
        beat("drain.r8b1", 32'd23, 3'd1, 64'd208, 1'b1);
        step();
        beat("drain.r10", 32'd27, 3'd3, 64'd77, 1'b1);
        step();
        beat("drain.r11", 32'd28, 3'd0, 64'd55, 1'b1);
        chk("drain.level", 64'(fifo_level), 64'd0);
        step();
        chk("drain.idle", 64'(s_valid), 64'd0);

        // Reset in the middle of a drain
        out_aktv = 6'b000011; set_val(0, 64'd1); set_val(1, 64'd2);
        step();
        step();
        out_aktv = '0;
        chk("mid.valid", 64'(s_valid),    64'd1);
        chk("mid.level", 64'(fifo_level), 64'd1);
        rst = 1'b1;
        #2;
        chk("mid.rst_valid",    64'(s_valid),    64'd0);
        chk("mid.rst_level",    64'(fifo_level), 64'd0);
        chk("mid.rst_overflow", 64'(overflow),   64'd0);
        chk("mid.rst_drop",     64'(drop_cnt),   64'd0);
        step();
        rst      = 1'b0;
        out_aktv = 6'b000001; set_val(0, 64'd9);
        step();
        out_aktv = '0;
        chk("post.valid0", 64'(s_valid),    64'd0);
        chk("post.level",  64'(fifo_level), 64'd1);
        step();
        beat("post.b0", 32'd0, 3'd0, 64'd9, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
